// File: rtl/redmule_x_scheduler_pkg.sv
// Shared types for the RedMulE X-buffer scheduler.
//  x_sched_state_e : scheduler FSM states.
//  x_buffer_ctrl_t : command word sent to the X buffer. It carries the strobes
//                    plus the latched leftover configuration. Field widths come
//                    from the default array geometry below.
//  x_buffer_flgs_t : X buffer status flags. Only 'full' is cross-checked here.
package redmule_x_scheduler_pkg;

   localparam int unsigned ARRAY_HEIGHT = 4;
   localparam int unsigned ARRAY_WIDTH  = 4;
   localparam int unsigned X_DEPTH      = 4;
   localparam int unsigned X_TILE_W     = 16;

   localparam int unsigned X_ROWS_W  = $clog2(ARRAY_WIDTH) + 1;
   localparam int unsigned X_COLS_W  = $clog2(ARRAY_HEIGHT * X_DEPTH) + 1;
   localparam int unsigned X_SLOTS_W = $clog2(X_DEPTH) + 1;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      PRIME,
      STREAM,
      DONE
   } x_sched_state_e;

   typedef struct packed {
      logic                 clear;
      logic                 load;
      logic                 d_shift;
      logic                 blck_shift;
      logic                 h_shift;
      logic [X_ROWS_W-1:0]  rows_lftovr;
      logic [X_COLS_W-1:0]  cols_lftovr;
      logic [X_SLOTS_W-1:0] slots;
   } x_buffer_ctrl_t;

   typedef struct packed {
      logic full;
   } x_buffer_flgs_t;

endpackage

// File: rtl/redmule_x_scheduler.sv
// RedMulE X-buffer scheduler.
// Turns streamer X row beats and engine consume strobes into the X buffer
// command stream. A job runs over n_tiles X tiles. Each tile is handled in
// four steps:
//   - FILL loads w_lim rows.
//   - PRIME issues one block shift.
//   - STREAM issues H h_shifts per depth slice, for d_lim slices.
//   - The scheduler then refills for the next tile, or pulses done_o.
// Ports:
//   clk_i, rst_i (sync, active high), clear_i (soft clear, also forwarded in ctrl_o)
//   start_i/n_tiles_i/rows_lftovr_i/cols_lftovr_i/slots_i : job start and configuration
//   x_valid_i/x_ready_o     : X row beat handshake; a load is issued on the accepting cycle
//   eng_ready_i/eng_valid_o : engine consume handshake
//   buf_full_i              : buffer full flag, cross-checked against the FSM
//   ctrl_o                  : x_buffer_ctrl_t command word
//   busy_o, done_o, err_o   : status outputs; err_o is sticky until the next start
// Optional build macro REDMULE_XSCHED_PERF_EN adds two saturating stall counters:
//   perf_fill_stall_o : FILL cycles without x_valid_i
//   perf_eng_stall_o  : STREAM cycles without eng_ready_i
module redmule_x_scheduler
   import redmule_x_scheduler_pkg::*;
#(
   parameter int unsigned H      = ARRAY_HEIGHT,
   parameter int unsigned W      = ARRAY_WIDTH,
   parameter int unsigned D      = X_DEPTH,
   parameter int unsigned TILE_W = X_TILE_W
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      clear_i,
   input  logic                      start_i,
   input  logic [TILE_W-1:0]         n_tiles_i,
   input  logic [$clog2(W):0]        rows_lftovr_i,
   input  logic [$clog2(H*D):0]      cols_lftovr_i,
   input  logic [$clog2(D):0]        slots_i,
   input  logic                      x_valid_i,
   output logic                      x_ready_o,
   input  logic                      eng_ready_i,
   output logic                      eng_valid_o,
   input  logic                      buf_full_i,
   output x_buffer_ctrl_t            ctrl_o,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      err_o
`ifdef REDMULE_XSCHED_PERF_EN
   ,
   output logic [31:0]               perf_fill_stall_o,
   output logic [31:0]               perf_eng_stall_o
`endif
);

   localparam int unsigned WC_W = $clog2(W) + 1;
   localparam int unsigned CC_W = $clog2(H*D) + 1;
   localparam int unsigned SC_W = $clog2(D) + 1;
   localparam int unsigned HC_W = (H > 1) ? $clog2(H) : 1;

   x_sched_state_e    state_q, state_d;
   logic [WC_W-1:0]   w_cnt_q, w_cnt_d;
   logic [HC_W-1:0]   h_cnt_q, h_cnt_d;
   logic [SC_W-1:0]   slice_cnt_q, slice_cnt_d;
   logic [TILE_W-1:0] tile_cnt_q, tile_cnt_d;
   logic [TILE_W-1:0] n_tiles_q, n_tiles_d;
   logic [WC_W-1:0]   rows_q, rows_d;
   logic [CC_W-1:0]   cols_q, cols_d;
   logic [SC_W-1:0]   slots_q, slots_d;
   logic              err_q, err_d;

   logic [WC_W-1:0]   w_lim;
   logic [SC_W-1:0]   d_lim;
   logic              start_acc;

   // Leftovers apply to every tile of the job.
   assign w_lim     = (rows_q != '0) ? rows_q : WC_W'(W);
   assign d_lim     = (cols_q != '0) ? slots_q : SC_W'(D);
   assign start_acc = (state_q == IDLE) && start_i;

   always_comb begin
      state_d     = state_q;
      w_cnt_d     = w_cnt_q;
      h_cnt_d     = h_cnt_q;
      slice_cnt_d = slice_cnt_q;
      tile_cnt_d  = tile_cnt_q;
      n_tiles_d   = n_tiles_q;
      rows_d      = rows_q;
      cols_d      = cols_q;
      slots_d     = slots_q;
      err_d       = err_q;
      x_ready_o   = 1'b0;
      eng_valid_o = 1'b0;
      done_o      = 1'b0;
      ctrl_o      = '0;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d     = FILL;
               n_tiles_d   = (n_tiles_i == '0) ? TILE_W'(1) : n_tiles_i;
               rows_d      = rows_lftovr_i;
               cols_d      = cols_lftovr_i;
               slots_d     = slots_i;
               w_cnt_d     = '0;
               h_cnt_d     = '0;
               slice_cnt_d = '0;
               tile_cnt_d  = '0;
               err_d       = 1'b0;
            end
         end
         FILL: begin
            x_ready_o   = 1'b1;
            ctrl_o.load = x_valid_i;
            if (buf_full_i) err_d = 1'b1;
            if (x_valid_i) begin
               if (w_cnt_q == w_lim - WC_W'(1)) begin
                  w_cnt_d = '0;
                  state_d = PRIME;
               end else begin
                  w_cnt_d = w_cnt_q + WC_W'(1);
               end
            end
         end
         PRIME: begin
            // The block shift moves the first half of the slices into place.
            // Streaming then walks every slice from index 0.
            ctrl_o.blck_shift = 1'b1;
            if (!buf_full_i) err_d = 1'b1;
            h_cnt_d     = '0;
            slice_cnt_d = '0;
            state_d     = STREAM;
         end
         STREAM: begin
            eng_valid_o = 1'b1;
            if (eng_ready_i) begin
               ctrl_o.h_shift = 1'b1;
               if (h_cnt_q == HC_W'(H-1)) begin
                  h_cnt_d = '0;
                  if (slice_cnt_q == d_lim - SC_W'(1)) begin
                     // Last slice of the tile: no depth shift past d_lim.
                     slice_cnt_d = '0;
                     if (tile_cnt_q == n_tiles_q - TILE_W'(1)) begin
                        state_d = DONE;
                     end else begin
                        tile_cnt_d = tile_cnt_q + TILE_W'(1);
                        w_cnt_d    = '0;
                        state_d    = FILL;
                     end
                  end else begin
                     slice_cnt_d    = slice_cnt_q + SC_W'(1);
                     ctrl_o.d_shift = 1'b1;
                  end
               end else begin
                  h_cnt_d = h_cnt_q + HC_W'(1);
               end
            end
         end
         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      ctrl_o.clear       = clear_i;
      ctrl_o.rows_lftovr = rows_q;
      ctrl_o.cols_lftovr = cols_q;
      ctrl_o.slots       = slots_q;
   end

   assign busy_o = (state_q != IDLE);
   assign err_o  = err_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         state_q     <= IDLE;
         w_cnt_q     <= '0;
         h_cnt_q     <= '0;
         slice_cnt_q <= '0;
         tile_cnt_q  <= '0;
         n_tiles_q   <= '0;
         rows_q      <= '0;
         cols_q      <= '0;
         slots_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         w_cnt_q     <= w_cnt_d;
         h_cnt_q     <= h_cnt_d;
         slice_cnt_q <= slice_cnt_d;
         tile_cnt_q  <= tile_cnt_d;
         n_tiles_q   <= n_tiles_d;
         rows_q      <= rows_d;
         cols_q      <= cols_d;
         slots_q     <= slots_d;
         err_q       <= err_d;
      end
   end

`ifdef REDMULE_XSCHED_PERF_EN
   logic [31:0] fill_stall_q, fill_stall_d;
   logic [31:0] eng_stall_q, eng_stall_d;

   always_comb begin
      fill_stall_d = fill_stall_q;
      eng_stall_d  = eng_stall_q;
      if (start_acc) begin
         fill_stall_d = '0;
         eng_stall_d  = '0;
      end else begin
         if ((state_q == FILL) && !x_valid_i && (fill_stall_q != '1))
            fill_stall_d = fill_stall_q + 32'd1;
         if ((state_q == STREAM) && !eng_ready_i && (eng_stall_q != '1))
            eng_stall_d = eng_stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         fill_stall_q <= '0;
         eng_stall_q  <= '0;
      end else begin
         fill_stall_q <= fill_stall_d;
         eng_stall_q  <= eng_stall_d;
      end
   end

   assign perf_fill_stall_o = fill_stall_q;
   assign perf_eng_stall_o  = eng_stall_q;
`else
   // start_acc only feeds the stall counters.
   logic unused_start_acc;
   assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_redmule_x_scheduler.sv
// Directed bench for redmule_x_scheduler with H=W=D=4.
// A negedge monitor counts strobes and records the cycle on which each event
// happens. Checks compare those counts and cycle offsets against values
// worked out by hand.
module tb_redmule_x_scheduler;
   import redmule_x_scheduler_pkg::*;

   logic           clk = 1'b0;
   logic           rst_i = 1'b1, clear_i = 1'b0, start_i = 1'b0;
   logic [15:0]    n_tiles_i = '0;
   logic [2:0]     rows_lftovr_i = '0;
   logic [4:0]     cols_lftovr_i = '0;
   logic [2:0]     slots_i = '0;
   logic           x_valid_i = 1'b0, eng_ready_i = 1'b0;
   logic           x_ready_o, eng_valid_o, buf_full_i;
   x_buffer_ctrl_t ctrl_o;
   logic           busy_o, done_o, err_o;
`ifdef REDMULE_XSCHED_PERF_EN
   logic [31:0]    perf_fill_stall_o, perf_eng_stall_o;
`endif
   logic           bad_full = 1'b0;

   // Buffer model: full exactly while the block shift is issued.
   assign buf_full_i = ctrl_o.blck_shift & ~bad_full;

   redmule_x_scheduler #(.H(4), .W(4), .D(4), .TILE_W(16)) dut (
      .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
      .n_tiles_i(n_tiles_i), .rows_lftovr_i(rows_lftovr_i),
      .cols_lftovr_i(cols_lftovr_i), .slots_i(slots_i),
      .x_valid_i(x_valid_i), .x_ready_o(x_ready_o),
      .eng_ready_i(eng_ready_i), .eng_valid_o(eng_valid_o),
      .buf_full_i(buf_full_i), .ctrl_o(ctrl_o), .busy_o(busy_o),
      .done_o(done_o), .err_o(err_o)
`ifdef REDMULE_XSCHED_PERF_EN
      , .perf_fill_stall_o(perf_fill_stall_o), .perf_eng_stall_o(perf_eng_stall_o)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic mon_clr = 1'b0;
   int n_load = 0, n_h = 0, n_d = 0, n_blck = 0, n_done = 0, n_fill_ev = 0, n_fill_ph = 0;
   int first_load = -1, last_load = -1, blck_at = -1, first_ev = -1, last_h = -1, done_at = -1;
   logic prev_xr = 1'b0;

   always @(negedge clk) begin
      if (mon_clr) begin
         n_load <= 0; n_h <= 0; n_d <= 0; n_blck <= 0; n_done <= 0;
         n_fill_ev <= 0; n_fill_ph <= 0;
         first_load <= -1; last_load <= -1; blck_at <= -1; first_ev <= -1;
         last_h <= -1; done_at <= -1; prev_xr <= 1'b0;
      end else begin
         if (ctrl_o.load) begin
            n_load <= n_load + 1;
            if (first_load < 0) first_load <= cyc;
            last_load <= cyc;
         end
         if (ctrl_o.blck_shift) begin n_blck <= n_blck + 1; blck_at <= cyc; end
         if (ctrl_o.h_shift) begin n_h <= n_h + 1; last_h <= cyc; end
         if (ctrl_o.d_shift) n_d <= n_d + 1;
         if (done_o) begin n_done <= n_done + 1; done_at <= cyc; end
         if (eng_valid_o && first_ev < 0) first_ev <= cyc;
         if (eng_valid_o && x_ready_o) n_fill_ev <= n_fill_ev + 1;
         if (x_ready_o && !prev_xr) n_fill_ph <= n_fill_ph + 1;
         prev_xr <= x_ready_o;
      end
   end

   int n_tests = 0, n_fail = 0;
   int s0 = 0;
   bit rnd_eng = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic clr_mon();
      mon_clr = 1'b1;
      @(negedge clk); #1;
      mon_clr = 1'b0;
   endtask

   // Start pulse. The cfg inputs are zeroed right after the pulse, so a
   // correct run depends on the values latched at start.
   task automatic start_job(input int nt, input int rl, input int cl, input int sl);
      n_tiles_i = 16'(nt); rows_lftovr_i = 3'(rl); cols_lftovr_i = 5'(cl); slots_i = 3'(sl);
      start_i = 1'b1;
      s0 = cyc;
      tick();
      start_i = 1'b0;
      n_tiles_i = '0; rows_lftovr_i = '0; cols_lftovr_i = '0; slots_i = '0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int k = 0;
      while (n_done == 0 && k < budget) begin
         tick();
         if (rnd_eng) eng_ready_i = 1'($urandom_range(0, 1));
         k++;
      end
      chk({tag, "_timeout"}, 64'(n_done != 0), 64'd1);
      eng_ready_i = 1'b1;
      tick();
   endtask

   initial begin
      repeat (3) tick();
      rst_i = 1'b0;
      tick();
      chk("rst_busy", 64'(busy_o), 0);
      chk("rst_ctrl", 64'(ctrl_o), 0);
      chk("rst_xready", 64'(x_ready_o), 0);
      chk("rst_engvalid", 64'(eng_valid_o), 0);
      chk("rst_done", 64'(done_o), 0);
      chk("rst_err", 64'(err_o), 0);

      // Test 1: one full tile with both handshakes held high.
      x_valid_i = 1'b1; eng_ready_i = 1'b1;
      clr_mon();
      start_job(1, 0, 0, 0);
      chk("t1_xready_lat", 64'(x_ready_o), 1);
      wait_done("t1", 200);
      chk("t1_loads", 64'(n_load), 4);
      chk("t1_first_load", 64'(first_load - s0), 1);
      chk("t1_last_load", 64'(last_load - s0), 4);
      chk("t1_blck_n", 64'(n_blck), 1);
      chk("t1_blck_cyc", 64'(blck_at - s0), 5);
      chk("t1_ev_lat", 64'(first_ev - last_load), 2);
      chk("t1_hshift", 64'(n_h), 16);
      chk("t1_dshift", 64'(n_d), 3);
      chk("t1_done_n", 64'(n_done), 1);
      chk("t1_done_lat", 64'(done_at - last_h), 1);
      chk("t1_err", 64'(err_o), 0);
      chk("t1_idle", 64'(busy_o), 0);

      // Test 2: row and column leftovers.
      clr_mon();
      start_job(1, 2, 5, 2);
      wait_done("t2", 200);
      chk("t2_loads", 64'(n_load), 2);
      chk("t2_blck_cyc", 64'(blck_at - s0), 3);
      chk("t2_hshift", 64'(n_h), 8);
      chk("t2_dshift", 64'(n_d), 1);
      chk("t2_done_n", 64'(n_done), 1);
      chk("t2_cfg_rows", 64'(ctrl_o.rows_lftovr), 2);
      chk("t2_cfg_cols", 64'(ctrl_o.cols_lftovr), 5);
      chk("t2_cfg_slots", 64'(ctrl_o.slots), 2);

      // Test 3: three tiles with a random engine.
      clr_mon();
      rnd_eng = 1'b1;
      start_job(3, 0, 0, 0);
      wait_done("t3", 1500);
      rnd_eng = 1'b0;
      chk("t3_loads", 64'(n_load), 12);
      chk("t3_fill_ph", 64'(n_fill_ph), 3);
      chk("t3_hshift", 64'(n_h), 48);
      chk("t3_dshift", 64'(n_d), 9);
      chk("t3_ev_in_fill", 64'(n_fill_ev), 0);
      chk("t3_done_n", 64'(n_done), 1);

      // Test 4: reset while streaming slice 1.
      clr_mon();
      start_job(1, 0, 0, 0);
      for (int k = 0; k < 100 && n_d == 0; k++) tick();
      chk("t4_in_slice1", 64'(n_d), 1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("t4_busy", 64'(busy_o), 0);
      chk("t4_ctrl", 64'(ctrl_o), 0);
      chk("t4_engvalid", 64'(eng_valid_o), 0);
      repeat (5) tick();
      chk("t4_no_done", 64'(n_done), 0);
      clr_mon();
      start_job(1, 0, 0, 0);
      wait_done("t4b", 200);
      chk("t4b_loads", 64'(n_load), 4);
      chk("t4b_hshift", 64'(n_h), 16);
      chk("t4b_dshift", 64'(n_d), 3);

      // Test 5: start while busy, then clear together with start.
      clr_mon();
      start_job(1, 0, 0, 0);
      tick();
      n_tiles_i = 16'd3; start_i = 1'b1;
      tick();
      start_i = 1'b0; n_tiles_i = '0;
      wait_done("t5", 200);
      chk("t5_loads", 64'(n_load), 4);
      repeat (3) tick();
      chk("t5_no_restart", 64'(busy_o), 0);
      clear_i = 1'b1; start_i = 1'b1; n_tiles_i = 16'd1;
      #1;
      chk("t5_clear_fwd", 64'(ctrl_o.clear), 1);
      tick();
      clear_i = 1'b0; start_i = 1'b0; n_tiles_i = '0;
      chk("t5_clr_start", 64'(busy_o), 0);
      chk("t5_clr_xready", 64'(x_ready_o), 0);
      start_job(1, 0, 0, 0);
      repeat (3) tick();
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      chk("t5_clr_mid", 64'(busy_o), 0);

      // Test 6: buffer not full during PRIME gives a sticky error.
      clr_mon();
      bad_full = 1'b1;
      start_job(1, 0, 0, 0);
      wait_done("t6", 200);
      bad_full = 1'b0;
      chk("t6_err", 64'(err_o), 1);
      repeat (3) tick();
      chk("t6_err_sticky", 64'(err_o), 1);
      clr_mon();
      start_job(1, 0, 0, 0);
      chk("t6_err_clr", 64'(err_o), 0);
      wait_done("t6b", 200);
      chk("t6b_err", 64'(err_o), 0);

`ifdef REDMULE_XSCHED_PERF_EN
      // Stall counters: x_valid_i held low for 7 FILL cycles.
      clr_mon();
      start_job(1, 0, 0, 0);
      x_valid_i = 1'b0;
      repeat (7) tick();
      x_valid_i = 1'b1;
      wait_done("perf", 200);
      chk("perf_fill", 64'(perf_fill_stall_o), 7);
      chk("perf_eng", 64'(perf_eng_stall_o), 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
